// File: rtl/rs_wakeup_select_if.sv
// Bundle between rename/dispatch, the CDB ports, the FU issue ports and the reservation station.
// The master side drives alloc/CDB/flush/iss_ready; the slave side (the RS) drives the rest.
interface rs_wakeup_select_if #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned FU_NUM    = 2,
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned VAL_W     = 32,
  parameter int unsigned PREG_W    = 7,
  parameter int unsigned PAYLOAD_W = 96
) ();
  localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

  logic                          flush;
  logic                          alloc_valid;
  logic                          alloc_ready;
  logic [PREG_W-1:0]             alloc_src1_tag;
  logic                          alloc_src1_rdy;
  logic [VAL_W-1:0]              alloc_src1_val;
  logic [PREG_W-1:0]             alloc_src2_tag;
  logic                          alloc_src2_rdy;
  logic [VAL_W-1:0]              alloc_src2_val;
  logic                          alloc_src2_used;
  logic [PAYLOAD_W-1:0]          alloc_payload;
  logic [CDB_NUM-1:0]            cdb_valid;
  logic [CDB_NUM*PREG_W-1:0]     cdb_tag;
  logic [CDB_NUM*VAL_W-1:0]      cdb_val;
  logic [FU_NUM-1:0]             iss_valid;
  logic [FU_NUM-1:0]             iss_ready;
  logic [FU_NUM*VAL_W-1:0]       iss_src1_val;
  logic [FU_NUM*VAL_W-1:0]       iss_src2_val;
  logic [FU_NUM*PAYLOAD_W-1:0]   iss_payload;
  logic [OCC_W-1:0]              occupancy;

  modport master (
    output flush, alloc_valid, alloc_src1_tag, alloc_src1_rdy, alloc_src1_val,
           alloc_src2_tag, alloc_src2_rdy, alloc_src2_val, alloc_src2_used, alloc_payload,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    input  alloc_ready, iss_valid, iss_src1_val, iss_src2_val, iss_payload, occupancy
  );

  modport slave (
    input  flush, alloc_valid, alloc_src1_tag, alloc_src1_rdy, alloc_src1_val,
           alloc_src2_tag, alloc_src2_rdy, alloc_src2_val, alloc_src2_used, alloc_payload,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    output alloc_ready, iss_valid, iss_src1_val, iss_src2_val, iss_payload, occupancy
  );
endinterface

// File: rtl/rs_wakeup_select.sv
// Reservation station: tag-based CDB wakeup with allocate-cycle bypass, age-matrix
// oldest-first selection onto FU_NUM issue ports, and a synchronous flush.
module rs_wakeup_select #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned FU_NUM    = 2,
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned VAL_W     = 32,
  parameter int unsigned PREG_W    = 7,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic               clk,
  input  logic               reset_n,
  rs_wakeup_select_if.slave  rs
);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]   valid_q,   valid_d;
  logic [ENTRIES-1:0]   s1_rdy_q,  s1_rdy_d;
  logic [ENTRIES-1:0]   s2_rdy_q,  s2_rdy_d;
  logic [ENTRIES-1:0]   s2_used_q, s2_used_d;
  logic [PREG_W-1:0]    s1_tag_q  [ENTRIES];
  logic [PREG_W-1:0]    s1_tag_d  [ENTRIES];
  logic [PREG_W-1:0]    s2_tag_q  [ENTRIES];
  logic [PREG_W-1:0]    s2_tag_d  [ENTRIES];
  logic [VAL_W-1:0]     s1_val_q  [ENTRIES];
  logic [VAL_W-1:0]     s1_val_d  [ENTRIES];
  logic [VAL_W-1:0]     s2_val_q  [ENTRIES];
  logic [VAL_W-1:0]     s2_val_d  [ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
  logic [PAYLOAD_W-1:0] payload_d [ENTRIES];
  logic [ENTRIES-1:0]   age_q     [ENTRIES];
  logic [ENTRIES-1:0]   age_d     [ENTRIES];
  logic [OCC_W-1:0]     occ_q,     occ_d;

  logic [ENTRIES-1:0]         elig_c;
  logic [ENTRIES-1:0]         issued_c;
  logic [OCC_W-1:0]           iss_cnt_c;
  logic [IDX_W-1:0]           free_idx_c;
  logic                       alloc_fire_c;
  logic [IDX_W-1:0]           sel_idx_c [FU_NUM];
  logic [FU_NUM-1:0]          iss_valid_c;
  logic [FU_NUM*VAL_W-1:0]    iss_src1_c;
  logic [FU_NUM*VAL_W-1:0]    iss_src2_c;
  logic [FU_NUM*PAYLOAD_W-1:0] iss_payload_c;

  assign elig_c       = valid_q & s1_rdy_q & (s2_rdy_q | ~s2_used_q);
  assign rs.alloc_ready = ~(&valid_q);
  assign alloc_fire_c = rs.alloc_valid & ~(&valid_q) & ~rs.flush;

  // Lowest-index free entry
  always_comb begin
    free_idx_c = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = IDX_W'(i);
    end
  end

  // Oldest-first selection: an entry wins if no other still-available eligible entry is older
  always_comb begin : select
    logic [ENTRIES-1:0] taken;
    logic               found;
    logic               older;
    taken         = '0;
    found         = 1'b0;
    older         = 1'b0;
    iss_valid_c   = '0;
    issued_c      = '0;
    iss_src1_c    = '0;
    iss_src2_c    = '0;
    iss_payload_c = '0;
    for (int k = 0; k < FU_NUM; k++) sel_idx_c[k] = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      found = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        older = 1'b0;
        for (int j = 0; j < ENTRIES; j++) begin
          if (elig_c[j] && !taken[j] && age_q[j][i]) older = 1'b1;
        end
        if (!found && elig_c[i] && !taken[i] && !older) begin
          found        = 1'b1;
          sel_idx_c[k] = IDX_W'(i);
        end
      end
      if (found) begin
        taken[sel_idx_c[k]] = 1'b1;
        iss_valid_c[k]      = ~rs.flush;
        if (!rs.flush && rs.iss_ready[k]) issued_c[sel_idx_c[k]] = 1'b1;
      end
      iss_src1_c[k*VAL_W +: VAL_W]        = s1_val_q[sel_idx_c[k]];
      iss_src2_c[k*VAL_W +: VAL_W]        = s2_val_q[sel_idx_c[k]];
      iss_payload_c[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[sel_idx_c[k]];
    end
  end

  always_comb begin
    iss_cnt_c = '0;
    for (int i = 0; i < ENTRIES; i++) iss_cnt_c = iss_cnt_c + OCC_W'(issued_c[i]);
  end

  assign rs.iss_valid    = iss_valid_c;
  assign rs.iss_src1_val = iss_src1_c;
  assign rs.iss_src2_val = iss_src2_c;
  assign rs.iss_payload  = iss_payload_c;
  assign rs.occupancy    = occ_q;

  // Next-state: issue frees, CDB wakeup, allocate with bypass; flush overrides everything
  always_comb begin
    valid_d   = valid_q & ~issued_c;
    s1_rdy_d  = s1_rdy_q;
    s2_rdy_d  = s2_rdy_q;
    s2_used_d = s2_used_q;
    s1_tag_d  = s1_tag_q;
    s2_tag_d  = s2_tag_q;
    s1_val_d  = s1_val_q;
    s2_val_d  = s2_val_q;
    payload_d = payload_q;
    age_d     = age_q;
    occ_d     = occ_q + OCC_W'(alloc_fire_c) - iss_cnt_c;
    if (rs.flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        // Descending port scan so the lowest matching port wins
        for (int p = CDB_NUM - 1; p >= 0; p--) begin
          if (valid_q[i] && rs.cdb_valid[p]) begin
            if (!s1_rdy_q[i] && rs.cdb_tag[p*PREG_W +: PREG_W] == s1_tag_q[i]) begin
              s1_rdy_d[i] = 1'b1;
              s1_val_d[i] = rs.cdb_val[p*VAL_W +: VAL_W];
            end
            if (!s2_rdy_q[i] && rs.cdb_tag[p*PREG_W +: PREG_W] == s2_tag_q[i]) begin
              s2_rdy_d[i] = 1'b1;
              s2_val_d[i] = rs.cdb_val[p*VAL_W +: VAL_W];
            end
          end
        end
      end
      if (alloc_fire_c) begin
        valid_d[free_idx_c]   = 1'b1;
        s1_tag_d[free_idx_c]  = rs.alloc_src1_tag;
        s1_rdy_d[free_idx_c]  = rs.alloc_src1_rdy;
        s1_val_d[free_idx_c]  = rs.alloc_src1_val;
        s2_tag_d[free_idx_c]  = rs.alloc_src2_tag;
        s2_rdy_d[free_idx_c]  = rs.alloc_src2_rdy;
        s2_val_d[free_idx_c]  = rs.alloc_src2_val;
        s2_used_d[free_idx_c] = rs.alloc_src2_used;
        payload_d[free_idx_c] = rs.alloc_payload;
        for (int p = CDB_NUM - 1; p >= 0; p--) begin
          if (rs.cdb_valid[p]) begin
            if (!rs.alloc_src1_rdy && rs.cdb_tag[p*PREG_W +: PREG_W] == rs.alloc_src1_tag) begin
              s1_rdy_d[free_idx_c] = 1'b1;
              s1_val_d[free_idx_c] = rs.cdb_val[p*VAL_W +: VAL_W];
            end
            if (!rs.alloc_src2_rdy && rs.cdb_tag[p*PREG_W +: PREG_W] == rs.alloc_src2_tag) begin
              s2_rdy_d[free_idx_c] = 1'b1;
              s2_val_d[free_idx_c] = rs.cdb_val[p*VAL_W +: VAL_W];
            end
          end
        end
        age_d[free_idx_c] = '0;
        for (int j = 0; j < ENTRIES; j++) age_d[j][free_idx_c] = valid_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      age_q   <= '{default: '0};
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      occ_q   <= occ_d;
    end
  end

  // Entry data is qualified by valid_q and needs no reset
  always_ff @(posedge clk) begin
    s1_rdy_q  <= s1_rdy_d;
    s2_rdy_q  <= s2_rdy_d;
    s2_used_q <= s2_used_d;
    s1_tag_q  <= s1_tag_d;
    s2_tag_q  <= s2_tag_d;
    s1_val_q  <= s1_val_d;
    s2_val_q  <= s2_val_d;
    payload_q <= payload_d;
  end
endmodule

// File: tb/tb_rs_wakeup_select.sv
// Scenario bench for rs_wakeup_select: expected issues are queued when stimulus is
// driven and popped at each issue fire; state is checked inline per scenario.
module tb_rs_wakeup_select;
  localparam int unsigned ENTRIES   = 8;
  localparam int unsigned FU_NUM    = 2;
  localparam int unsigned CDB_NUM   = 2;
  localparam int unsigned VAL_W     = 32;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned PAYLOAD_W = 96;

  typedef struct {
    int                   fu;
    logic [VAL_W-1:0]     s1;
    logic [VAL_W-1:0]     s2;
    bit                   chk_s2;
    logic [PAYLOAD_W-1:0] pl;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  rs_wakeup_select_if #(
    .ENTRIES(ENTRIES), .FU_NUM(FU_NUM), .CDB_NUM(CDB_NUM),
    .VAL_W(VAL_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)
  ) rsif ();

  rs_wakeup_select #(
    .ENTRIES(ENTRIES), .FU_NUM(FU_NUM), .CDB_NUM(CDB_NUM),
    .VAL_W(VAL_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rs(rsif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int fu, input logic [31:0] s1, input logic [31:0] s2,
                              input bit chk2, input logic [95:0] pl);
    exp_t e;
    e.fu = fu; e.s1 = s1; e.s2 = s2; e.chk_s2 = chk2; e.pl = pl;
    return e;
  endfunction

  task automatic idle_inputs();
    rsif.flush = 1'b0;
    rsif.alloc_valid = 1'b0;
    rsif.alloc_src1_tag = '0; rsif.alloc_src1_rdy = 1'b0; rsif.alloc_src1_val = '0;
    rsif.alloc_src2_tag = '0; rsif.alloc_src2_rdy = 1'b0; rsif.alloc_src2_val = '0;
    rsif.alloc_src2_used = 1'b0; rsif.alloc_payload = '0;
    rsif.cdb_valid = '0; rsif.cdb_tag = '0; rsif.cdb_val = '0;
    rsif.iss_ready = '0;
  endtask

  task automatic drive_alloc(input logic s1r, input logic [6:0] s1t, input logic [31:0] s1v,
                             input logic s2r, input logic [6:0] s2t, input logic [31:0] s2v,
                             input logic s2u, input logic [95:0] pl);
    rsif.alloc_valid = 1'b1;
    rsif.alloc_src1_rdy = s1r; rsif.alloc_src1_tag = s1t; rsif.alloc_src1_val = s1v;
    rsif.alloc_src2_rdy = s2r; rsif.alloc_src2_tag = s2t; rsif.alloc_src2_val = s2v;
    rsif.alloc_src2_used = s2u; rsif.alloc_payload = pl;
  endtask

  // One clock: score issue fires at the falling edge, return just after the rising edge
  task automatic cycle();
    exp_t e;
    logic [VAL_W-1:0]     g1, g2;
    logic [PAYLOAD_W-1:0] gp;
    @(negedge clk);
    for (int k = 0; k < FU_NUM; k++) begin
      if (rsif.iss_valid[k] && rsif.iss_ready[k]) begin
        g1 = rsif.iss_src1_val[k*VAL_W +: VAL_W];
        g2 = rsif.iss_src2_val[k*VAL_W +: VAL_W];
        gp = rsif.iss_payload[k*PAYLOAD_W +: PAYLOAD_W];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_issue fu=%0d got_payload=%0h exp=none", k, gp);
        end else begin
          e = exp_q.pop_front();
          if (e.fu != k || g1 !== e.s1 || (e.chk_s2 && g2 !== e.s2) || gp !== e.pl) begin
            errors++;
            $display("FAIL sb_issue got fu=%0d s1=%0h s2=%0h pl=%0h exp fu=%0d s1=%0h s2=%0h pl=%0h",
                     k, g1, g2, gp, e.fu, e.s1, e.s2, e.pl);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    checks++;
    if (rsif.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%b exp=1", rsif.alloc_ready); end
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid got=%b exp=00", rsif.iss_valid); end
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", rsif.occupancy); end
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic_issue();
    rsif.iss_ready = 2'b11;
    drive_alloc(1'b1, 7'd1, 32'd5, 1'b1, 7'd2, 32'd7, 1'b1, 96'd1);
    exp_q.push_back(mk(0, 32'd5, 32'd7, 1'b1, 96'd1));
    cycle();
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ1 got=%0d exp=1", rsif.occupancy); end
    checks++;
    if (rsif.iss_valid !== 2'b01) begin errors++; $display("FAIL basic_iss_valid got=%b exp=01", rsif.iss_valid); end
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ0 got=%0d exp=0", rsif.occupancy); end
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got=%b exp=00", rsif.iss_valid); end
  endtask

  task automatic test_wakeup();
    rsif.iss_ready = 2'b11;
    drive_alloc(1'b0, 7'd12, 32'd0, 1'b1, 7'd12, 32'd1, 1'b1, 96'd2);
    cycle();
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL wake_not_ready got=%b exp=00", rsif.iss_valid); end
    cycle();
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL wake_still_waiting got=%b exp=00", rsif.iss_valid); end
    rsif.cdb_valid = 2'b11;
    rsif.cdb_tag = {7'd12, 7'd3};
    rsif.cdb_val = {32'h0000_00AB, 32'h0000_0011};
    exp_q.push_back(mk(0, 32'hAB, 32'd1, 1'b1, 96'd2));
    cycle();
    rsif.cdb_valid = '0;
    #1;
    checks++;
    if (rsif.iss_valid !== 2'b01) begin errors++; $display("FAIL wake_iss_valid got=%b exp=01", rsif.iss_valid); end
    checks++;
    if (rsif.iss_src1_val[31:0] !== 32'hAB) begin errors++; $display("FAIL wake_src1 got=%0h exp=ab", rsif.iss_src1_val[31:0]); end
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL wake_occ got=%0d exp=0", rsif.occupancy); end
  endtask

  task automatic test_bypass();
    rsif.iss_ready = 2'b11;
    drive_alloc(1'b1, 7'd1, 32'd4, 1'b0, 7'd9, 32'hDEAD, 1'b1, 96'd3);
    rsif.cdb_valid = 2'b11;
    rsif.cdb_tag = {7'd9, 7'd9};
    rsif.cdb_val = {32'h44, 32'h33};
    exp_q.push_back(mk(0, 32'd4, 32'h33, 1'b1, 96'd3));
    cycle();
    rsif.cdb_valid = '0;
    drive_alloc(1'b1, 7'd1, 32'h77, 1'b0, 7'd50, 32'd0, 1'b0, 96'd4);
    exp_q.push_back(mk(0, 32'h77, 32'd0, 1'b0, 96'd4));
    #1;
    checks++;
    if (rsif.iss_valid !== 2'b01) begin errors++; $display("FAIL bypass_iss_valid got=%b exp=01", rsif.iss_valid); end
    checks++;
    if (rsif.iss_src2_val[31:0] !== 32'h33) begin errors++; $display("FAIL bypass_src2 got=%0h exp=33", rsif.iss_src2_val[31:0]); end
    cycle();
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.iss_payload[95:0] !== 96'd4) begin errors++; $display("FAIL src2_unused_payload got=%0h exp=4", rsif.iss_payload[95:0]); end
    checks++;
    if (rsif.occupancy !== 4'd1) begin errors++; $display("FAIL bypass_occ_net got=%0d exp=1", rsif.occupancy); end
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL bypass_occ0 got=%0d exp=0", rsif.occupancy); end
  endtask

  task automatic test_full_oldest_first();
    rsif.iss_ready = 2'b00;
    for (int i = 0; i < 8; i++) begin
      drive_alloc((i == 2 || i == 7), (i == 5) ? 7'd40 : 7'(30 + i), 32'(32'h100 + i),
                  1'b1, 7'd0, 32'(32'h200 + i), 1'b1, 96'(200 + i));
      cycle();
    end
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got=%0d exp=8", rsif.occupancy); end
    checks++;
    if (rsif.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got=%b exp=0", rsif.alloc_ready); end
    checks++;
    if (rsif.iss_payload[95:0] !== 96'd202 || rsif.iss_payload[191:96] !== 96'd207) begin
      errors++; $display("FAIL full_pre_select got=%0d/%0d exp=202/207", rsif.iss_payload[95:0], rsif.iss_payload[191:96]);
    end
    exp_q.push_back(mk(0, 32'h102, 32'h202, 1'b1, 96'd202));
    exp_q.push_back(mk(1, 32'h107, 32'h207, 1'b1, 96'd207));
    rsif.iss_ready = 2'b11;
    cycle();
    rsif.iss_ready = 2'b00;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd6) begin errors++; $display("FAIL full_occ6 got=%0d exp=6", rsif.occupancy); end
    drive_alloc(1'b0, 7'd40, 32'd0, 1'b1, 7'd0, 32'h300, 1'b1, 96'd300);
    cycle();
    drive_alloc(1'b0, 7'd40, 32'd0, 1'b1, 7'd0, 32'h301, 1'b1, 96'd301);
    cycle();
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd8 || rsif.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL refill got occ=%0d rdy=%b exp occ=8 rdy=0", rsif.occupancy, rsif.alloc_ready);
    end
    rsif.iss_ready = 2'b11;
    rsif.cdb_valid = 2'b01;
    rsif.cdb_tag = {7'd0, 7'd40};
    rsif.cdb_val = {32'd0, 32'h5A5A};
    exp_q.push_back(mk(0, 32'h5A5A, 32'h205, 1'b1, 96'd205));
    exp_q.push_back(mk(1, 32'h5A5A, 32'h300, 1'b1, 96'd300));
    exp_q.push_back(mk(0, 32'h5A5A, 32'h301, 1'b1, 96'd301));
    cycle();
    rsif.cdb_valid = '0;
    #1;
    checks++;
    if (rsif.iss_valid !== 2'b11 || rsif.iss_payload[95:0] !== 96'd205 || rsif.iss_payload[191:96] !== 96'd300) begin
      errors++; $display("FAIL wake3_select got v=%b %0d/%0d exp v=11 205/300", rsif.iss_valid, rsif.iss_payload[95:0], rsif.iss_payload[191:96]);
    end
    cycle();
    checks++;
    if (rsif.iss_valid !== 2'b01 || rsif.iss_payload[95:0] !== 96'd301) begin
      errors++; $display("FAIL wake3_third got v=%b %0d exp v=01 301", rsif.iss_valid, rsif.iss_payload[95:0]);
    end
    rsif.cdb_valid = 2'b11; rsif.cdb_tag = {7'd31, 7'd30}; rsif.cdb_val = {32'hA1, 32'hA0};
    exp_q.push_back(mk(0, 32'hA0, 32'h200, 1'b1, 96'd200));
    exp_q.push_back(mk(1, 32'hA1, 32'h201, 1'b1, 96'd201));
    cycle();
    rsif.cdb_tag = {7'd34, 7'd33}; rsif.cdb_val = {32'hA4, 32'hA3};
    exp_q.push_back(mk(0, 32'hA3, 32'h203, 1'b1, 96'd203));
    exp_q.push_back(mk(1, 32'hA4, 32'h204, 1'b1, 96'd204));
    cycle();
    rsif.cdb_valid = 2'b01; rsif.cdb_tag = {7'd0, 7'd36}; rsif.cdb_val = {32'd0, 32'hA6};
    exp_q.push_back(mk(0, 32'hA6, 32'h206, 1'b1, 96'd206));
    cycle();
    rsif.cdb_valid = '0;
    cycle();
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL drain_occ got=%0d exp=0", rsif.occupancy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_missing_issues got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_backpressure();
    rsif.iss_ready = 2'b00;
    drive_alloc(1'b1, 7'd1, 32'd1, 1'b1, 7'd2, 32'd2, 1'b1, 96'd400);
    cycle();
    rsif.alloc_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rsif.iss_valid[0] !== 1'b1 || rsif.iss_payload[95:0] !== 96'd400 || rsif.occupancy !== 4'd1) begin
        errors++; $display("FAIL stall_hold c=%0d got v=%b pl=%0d occ=%0d exp v=1 pl=400 occ=1",
                           c, rsif.iss_valid[0], rsif.iss_payload[95:0], rsif.occupancy);
      end
      cycle();
    end
    rsif.iss_ready = 2'b01;
    drive_alloc(1'b1, 7'd1, 32'd3, 1'b1, 7'd2, 32'd4, 1'b1, 96'd401);
    exp_q.push_back(mk(0, 32'd1, 32'd2, 1'b1, 96'd400));
    exp_q.push_back(mk(0, 32'd3, 32'd4, 1'b1, 96'd401));
    cycle();
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd1) begin errors++; $display("FAIL alloc_and_issue_occ got=%0d exp=1", rsif.occupancy); end
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0) begin errors++; $display("FAIL stall_drain_occ got=%0d exp=0", rsif.occupancy); end
  endtask

  task automatic test_flush();
    rsif.iss_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      drive_alloc(1'b1, 7'd1, 32'(i), 1'b1, 7'd2, 32'(i), 1'b1, 96'(500 + i));
      cycle();
    end
    #1;
    checks++;
    if (rsif.occupancy !== 4'd4 || rsif.iss_valid !== 2'b11) begin
      errors++; $display("FAIL preflush got occ=%0d v=%b exp occ=4 v=11", rsif.occupancy, rsif.iss_valid);
    end
    drive_alloc(1'b1, 7'd1, 32'd9, 1'b1, 7'd2, 32'd9, 1'b1, 96'd599);
    rsif.flush = 1'b1;
    rsif.iss_ready = 2'b11;
    #1;
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL flush_iss_valid got=%b exp=00", rsif.iss_valid); end
    cycle();
    rsif.flush = 1'b0;
    rsif.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd0 || rsif.iss_valid !== 2'b00 || rsif.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL postflush got occ=%0d v=%b rdy=%b exp occ=0 v=00 rdy=1", rsif.occupancy, rsif.iss_valid, rsif.alloc_ready);
    end
    cycle();
    checks++;
    if (rsif.iss_valid !== 2'b00) begin errors++; $display("FAIL flush_no_alloc got=%b exp=00", rsif.iss_valid); end
  endtask

  task automatic test_reset_mid();
    rsif.iss_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      drive_alloc(1'b1, 7'd1, 32'(i), 1'b1, 7'd2, 32'(i), 1'b1, 96'(600 + i));
      cycle();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rsif.occupancy !== 4'd0 || rsif.iss_valid !== 2'b00 || rsif.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got occ=%0d v=%b rdy=%b exp occ=0 v=00 rdy=1", rsif.occupancy, rsif.iss_valid, rsif.alloc_ready);
    end
    cycle();
    rsif.alloc_valid = 1'b0;
    reset_n = 1'b1;
    cycle();
    checks++;
    if (rsif.occupancy !== 4'd0 || rsif.iss_valid !== 2'b00) begin
      errors++; $display("FAIL after_reset got occ=%0d v=%b exp occ=0 v=00", rsif.occupancy, rsif.iss_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_full_oldest_first();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_wakeup_select.md
Name: rs_wakeup_select

Overview:
Parametrised reservation station with tag-based operand wakeup from multiple CDB ports, oldest-first selection to multiple FUs, valid/ready backpressure on both sides, and a flush input.
- Sits between rename/dispatch and the FU array.
- Replaces the fixed-FU, register-status-polling RS.
- Instruction payload (control, dst preg, immediate, pc, ROB tag) is carried opaquely.

Parameters:
ENTRIES, 8, number of RS entries (>=2)
FU_NUM, 2, number of issue ports / FUs (>=1)
CDB_NUM, 2, number of CDB broadcast ports (>=1)
VAL_W, 32, operand value width
PREG_W, 7, physical register tag width
PAYLOAD_W, 96, opaque payload width (control, dst, imm, pc, ROB tag packed by the instantiating block)

Ports:
clk  in  1  clock; one clock; reset is asynchronous and active-low
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all entries
alloc_valid  in  1  new instruction offered
alloc_ready  out  1  at least one free entry
alloc_src1_tag  in  PREG_W  src1 physical tag
alloc_src1_rdy  in  1  src1 value already valid
alloc_src1_val  in  VAL_W  src1 value (meaningful if rdy)
alloc_src2_tag  in  PREG_W  src2 physical tag
alloc_src2_rdy  in  1  src2 value already valid
alloc_src2_val  in  VAL_W  src2 value
alloc_src2_used  in  1  instruction consumes src2
alloc_payload  in  PAYLOAD_W  opaque payload
cdb_valid  in  CDB_NUM  per-port broadcast valid
cdb_tag  in  CDB_NUM*PREG_W  per-port tag, port p at [p*PREG_W +: PREG_W]
cdb_val  in  CDB_NUM*VAL_W  per-port value
iss_valid  out  FU_NUM  issue offer per FU
iss_ready  in  FU_NUM  FU accepts
iss_src1_val  out  FU_NUM*VAL_W  operand 1 per FU
iss_src2_val  out  FU_NUM*VAL_W  operand 2 per FU
iss_payload  out  FU_NUM*PAYLOAD_W  payload per FU
occupancy  out  $clog2(ENTRIES+1)  valid entry count

Behaviour:
- Reset (async, reset_n=0): all entry valid bits and age matrix cleared; alloc_ready=1, iss_valid=0, occupancy=0. Entry data fields need no reset.
- Entry state: valid, s1_rdy/tag/val, s2_rdy/tag/val, s2_used, payload, age row. age[i][j]=1 means entry i is older than entry j.
- alloc_ready = any entry invalid. It is computed from registered state only, so an entry freed by issue this cycle is not reusable until the next cycle.
- Allocate: alloc_fire = alloc_valid & alloc_ready & ~flush.
  - Writes the lowest-index invalid entry.
  - Sets age[new][*]=0 and age[*][new]=1 for all currently valid entries.
- Allocate-cycle bypass: if a source is not ready and cdb_valid[p] with cdb_tag[p]==that tag, capture cdb_val[p] and set rdy=1. Lowest matching p wins.
- Wakeup: every cycle, for each valid entry and each not-ready source, a matching valid CDB port captures its value and sets rdy. Lowest matching p wins. Ready sources never change.
- Eligibility is from registered state: valid & s1_rdy & (s2_rdy | ~s2_used). Wakeup at edge N makes the entry eligible in cycle N+1. Allocate at edge N with both sources ready also gives iss_valid at N+1.
- Select (combinational):
  - FU0 takes the oldest eligible entry.
  - FU k takes the oldest eligible entry not taken by FUs 0..k-1.
  - iss_valid[k]=1 if one exists. iss_* reflect that entry's fields.
  - iss_valid does not depend on iss_ready.
- Issue fire: iss_valid[k] & iss_ready[k] clears that entry's valid at the edge. An unfired selection keeps its entry, which is offered again next cycle.
- flush=1: iss_valid forced 0; all valid bits cleared at the edge; alloc and CDB inputs ignored that cycle.
- occupancy: registered count; +1 on alloc_fire, -1 per issue fire, net value applied in one cycle; 0 after flush.
- Full (occupancy==ENTRIES): alloc_ready=0, alloc_valid is held off by the upstream block. Simultaneous issue does not open a slot until the next cycle.
- Empty: iss_valid=0.
- Reset mid-operation discards all entries immediately. Outputs return to reset values asynchronously.

Test Plan:
- Both srcs rdy, src1_val=5, src2_val=7, alloc at cycle 0, iss_ready=1 -> iss_valid[0]=1 at cycle 1 with vals 5/7, occupancy 1->0 at cycle 2.
- Alloc src1_tag=12 not rdy; cdb_valid[1]=1, tag 12, val 0xAB at cycle 3 -> iss_valid at cycle 4, iss_src1_val=0xAB.
- Alloc with not-ready src2_tag=9 in the same cycle as CDB tag 9, val 0x33 -> bypass captured, issue next cycle with src2=0x33.
- Fill all 8 entries not ready -> alloc_ready=0, occupancy=8. Wake entries 5, 2, 7 (allocated in that order) on one cycle, FU_NUM=2 -> FU0 gets entry 5, FU1 gets entry 2, entry 7 issues the following cycle.
- iss_ready[0]=0 for 3 cycles with an eligible entry -> iss_valid[0] stays 1 with stable payload; entry not freed.
- 4 valid entries, flush=1 with alloc_valid=1 -> occupancy=0 next cycle, iss_valid=0, no entry allocated. Repeat with reset_n low mid-burst -> immediate clear.
